// File: rtl/pwm_pkg.sv
// Shared definitions for the motor PWM blocks (generator and capture).
//   DUTY_W / DUTY_MAX : duty scale 0..127 out of 128
//   cap_state_e       : capture FSM states
//   DIR_CW / DIR_CCW  : direction encoding (bit1 of the PWM pair = clockwise)
package pwm_pkg;

    localparam int unsigned       DUTY_W   = 7;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 7'd127;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } cap_state_e;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

endpackage

// File: rtl/pwm_capture_if.sv
// Measurement report bundle produced by pwm_capture.
//   o_duty      : floor(high*128/period), saturated to 127
//   o_direction : 1 clockwise, 0 counterclockwise
//   o_period    : last measured period in clock cycles
//   o_valid     : one-cycle strobe, report fields updated
//   o_timeout   : level, no rising edge for TIMEOUT cycles
//   o_err       : strobe, both PWM lines high together
// master = capture block (drives), slave = consumer (reads).
interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    logic [DUTY_W-1:0] o_duty;
    logic              o_direction;
    logic [CNT_W-1:0]  o_period;
    logic              o_valid;
    logic              o_timeout;
    logic              o_err;

    modport master (
        output o_duty, o_direction, o_period, o_valid, o_timeout, o_err
    );

    modport slave (
        input o_duty, o_direction, o_period, o_valid, o_timeout, o_err
    );
endinterface

// File: rtl/pwm_div_seq.sv
// Sequential restoring divider producing floor(dividend*128/divisor), 7 bits,
// one quotient bit per cycle. Operands load on start_i while idle; done_o is
// a one-cycle strobe 8 cycles after the start cycle. abort_i kills a division.
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   start_i, abort_i     : load operands / cancel
//   dividend_i, divisor_i: high count and period count (dividend <= divisor)
//   busy_o, done_o       : busy covers the done cycle as well
//   quot_o               : saturated 7-bit quotient
module pwm_div_seq
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [CNT_W-1:0]  dividend_i,
    input  logic [CNT_W-1:0]  divisor_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DUTY_W-1:0] quot_o
);
    localparam logic [2:0] LAST_STEP = 3'(DUTY_W - 1);

    logic [CNT_W-1:0]  rem_q, dvs_q;
    logic [DUTY_W-1:0] quo_q;
    logic [2:0]        step_q;
    logic              run_q, done_q, sat_q;

    // The <<7 of the dividend is folded into shifting the remainder left each
    // step; rem < divisor always holds, so the low CNT_W bits of the
    // difference are exact.
    logic [CNT_W:0]   rem2;
    logic [CNT_W-1:0] diff;
    logic             ge;

    assign rem2 = {rem_q, 1'b0};
    assign diff = rem2[CNT_W-1:0] - dvs_q;
    assign ge   = (rem2 >= {1'b0, dvs_q});

    always_ff @(posedge clk_i) begin
        if (!rst_ni || abort_i) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !run_q && !done_q) begin
                rem_q  <= dividend_i;
                dvs_q  <= divisor_i;
                quo_q  <= '0;
                step_q <= '0;
                run_q  <= 1'b1;
                sat_q  <= (dividend_i >= divisor_i);
            end else if (run_q) begin
                rem_q  <= ge ? diff : rem2[CNT_W-1:0];
                quo_q  <= {quo_q[DUTY_W-2:0], ge};
                step_q <= step_q + 3'd1;
                if (step_q == LAST_STEP) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o = run_q | done_q;
    assign done_o = done_q;
    assign quot_o = sat_q ? DUTY_MAX : quo_q;

endmodule

// File: rtl/pwm_capture.sv
// Receive side of the motor PWM pair: measures duty (0..127/128), direction
// and period once per PWM period, flags stuck lines via timeout and the
// illegal both-high state.
//   i_sys_clk  : clock
//   i_rst      : synchronous active-low reset
//   i_pwm_wave : PWM pair, asynchronous (bit1 clockwise, bit0 counterclockwise)
//   cap        : report bundle (duty, direction, period, valid, timeout, err)
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          i_sys_clk,
    input  logic          i_rst,
    input  logic [1:0]    i_pwm_wave,
    pwm_capture_if.master cap
);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_PRE = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    cap_state_e        state_q, state_d;
    logic [1:0]        sync1_q, sync_q;
    logic              act_q;
    logic [CNT_W-1:0]  per_q, per_d, high_q, high_d;
    logic              dir_cur_q, dir_cur_d;
    logic [CNT_W-1:0]  pend_per_q;
    logic              pend_dir_q;
    logic [DUTY_W-1:0] duty_q;
    logic              dir_q, valid_q, timeout_q;
    logic [CNT_W-1:0]  period_q;

    logic              act, rise, err_now, to_hit, snap, to_evt;
    logic              div_busy, div_done;
    logic [DUTY_W-1:0] div_quot;

    assign act     = sync_q[1] | sync_q[0];
    assign rise    = act & ~act_q;
    assign err_now = &sync_q;
    assign to_hit  = (per_q == TO_PRE);

    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        high_d    = high_q;
        dir_cur_d = dir_cur_q;
        snap      = 1'b0;
        to_evt    = 1'b0;
        if (err_now) begin
            state_d = IDLE;
            per_d   = '0;
            high_d  = '0;
        end else if (rise) begin
            // Rise both closes the running period and opens the next one.
            state_d   = MEAS;
            snap      = (state_q == MEAS);
            per_d     = ONE;
            high_d    = ONE;
            dir_cur_d = sync_q[1];
        end else begin
            // per_cnt saturates at TIMEOUT; the timeout event fires once.
            if (per_q != TO_MAX) begin
                per_d = per_q + ONE;
                if (act) begin
                    high_d = high_q + ONE;
                end
            end
            if (to_hit) begin
                state_d = IDLE;
                to_evt  = 1'b1;
            end
        end
    end

    pwm_div_seq #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk_i      (i_sys_clk),
        .rst_ni     (i_rst),
        .start_i    (snap),
        .abort_i    (err_now),
        .dividend_i (high_q),
        .divisor_i  (per_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quot_o     (div_quot)
    );

    always_ff @(posedge i_sys_clk) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            sync1_q    <= '0;
            sync_q     <= '0;
            act_q      <= 1'b0;
            per_q      <= '0;
            high_q     <= '0;
            dir_cur_q  <= 1'b0;
            pend_per_q <= '0;
            pend_dir_q <= 1'b0;
            duty_q     <= '0;
            dir_q      <= 1'b0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            sync1_q   <= i_pwm_wave;
            sync_q    <= sync1_q;
            act_q     <= act;
            state_q   <= state_d;
            per_q     <= per_d;
            high_q    <= high_d;
            dir_cur_q <= dir_cur_d;
            // A snapshot taken while the divider is busy is simply dropped.
            if (snap && !div_busy) begin
                pend_per_q <= per_q;
                pend_dir_q <= dir_cur_q;
            end
            valid_q <= 1'b0;
            if (div_done && !err_now) begin
                duty_q   <= div_quot;
                dir_q    <= pend_dir_q;
                period_q <= pend_per_q;
                valid_q  <= 1'b1;
            end else if (to_evt) begin
                duty_q    <= act ? DUTY_MAX : '0;
                period_q  <= '0;
                valid_q   <= 1'b1;
                timeout_q <= 1'b1;
            end
            if (rise && !err_now) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign cap.o_duty      = duty_q;
    assign cap.o_direction = dir_q;
    assign cap.o_period    = period_q;
    assign cap.o_valid     = valid_q;
    assign cap.o_timeout   = timeout_q;
    assign cap.o_err       = err_now;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table of PWM frames plus hand sequences for timeout,
// illegal state and reset-abort. Expected reports go into a queue when the
// closing rise is driven and are compared when o_valid appears.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 1024;

    typedef struct {
        logic [6:0]  duty;
        logic        dir;
        logic [15:0] period;
        logic        tmo;
        longint      cyc;
    } sb_t;

    typedef struct {
        int unsigned per;
        int unsigned hi;
        bit          dir;
        logic [6:0]  duty;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] wave = 2'b00;
    longint     cyc = 0;
    bit         mon_en = 1'b0;

    int checks = 0;
    int failures = 0;

    sb_t    sb[$];
    sb_t    mon_e;
    bit     have_prev = 1'b0;
    bit     prev_dir;
    int unsigned prev_per, prev_hi;
    logic [6:0] prev_duty;
    longint last_start_c = -1000;
    longint rise_c = 0;
    logic   last_dir = 1'b0;

    vec_t vecs[8];

    pwm_capture_if #(.CNT_W(CNT_W)) cap_if ();

    pwm_capture #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_sys_clk  (clk),
        .i_rst      (rst_n),
        .i_pwm_wave (wave),
        .cap        (cap_if.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] duty_of(input int unsigned hi, input int unsigned per);
        int unsigned q;
        q = hi * 128 / per;
        return (q > 127) ? 7'd127 : q[6:0];
    endfunction

    // Drive a rising edge. The frame it closes is reported 11 cycles later
    // (2 sync stages + 9), unless the divider is still busy with a snapshot
    // started less than 9 cycles ago.
    task automatic rise(input bit dir, input int unsigned per, input int unsigned hi,
                        input logic [6:0] duty);
        sb_t e;
        if (have_prev && (cyc >= last_start_c + 9)) begin
            e.duty   = prev_duty;
            e.dir    = prev_dir;
            e.period = 16'(prev_per);
            e.tmo    = 1'b0;
            e.cyc    = cyc + 11;
            sb.push_back(e);
            last_start_c = cyc;
            last_dir     = prev_dir;
        end
        have_prev = 1'b1;
        prev_dir  = dir;
        prev_per  = per;
        prev_hi   = hi;
        prev_duty = duty;
        rise_c    = cyc;
        wave      = dir ? 2'b10 : 2'b01;
    endtask

    task automatic frame(input bit dir, input int unsigned per, input int unsigned hi,
                         input logic [6:0] duty);
        rise(dir, per, hi, duty);
        step(hi);
        wave = 2'b00;
        step(per - hi);
    endtask

    // Open frame never closes: timeout report TIMEOUT cycles after its edge.
    task automatic push_timeout(input bit line_high);
        sb_t e;
        e.duty   = line_high ? 7'd127 : 7'd0;
        e.dir    = last_dir;
        e.period = 16'd0;
        e.tmo    = 1'b1;
        e.cyc    = rise_c + 2 + TIMEOUT;
        sb.push_back(e);
        have_prev = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_duty"},    cap_if.o_duty, 0);
        chk({tag, "_dir"},     cap_if.o_direction, 0);
        chk({tag, "_period"},  cap_if.o_period, 0);
        chk({tag, "_valid"},   cap_if.o_valid, 0);
        chk({tag, "_timeout"}, cap_if.o_timeout, 0);
        chk({tag, "_err"},     cap_if.o_err, 0);
    endtask

    always @(negedge clk) begin
        if (mon_en && cap_if.o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid at cycle %0d: duty=%0d period=%0d, expected no valid",
                         cyc, cap_if.o_duty, cap_if.o_period);
            end else begin
                mon_e = sb.pop_front();
                chk("valid_cycle", cyc, mon_e.cyc);
                chk("duty",        cap_if.o_duty, mon_e.duty);
                chk("direction",   cap_if.o_direction, mon_e.dir);
                chk("period",      cap_if.o_period, mon_e.period);
                chk("timeout_lvl", cap_if.o_timeout, mon_e.tmo);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog at cycle %0d: simulation did not finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{128,  64, DIR_CW,  7'd64};
        vecs[1] = '{200,  50, DIR_CCW, 7'd32};
        vecs[2] = '{128,   1, DIR_CW,  7'd1};
        vecs[3] = '{128, 127, DIR_CW,  7'd127};
        vecs[4] = '{100,  33, DIR_CCW, 7'd42};
        vecs[5] = '{9,     4, DIR_CW,  7'd56};
        vecs[6] = '{1000, 999, DIR_CCW, 7'd127};
        vecs[7] = '{50,   49, DIR_CW,  7'd125};

        // Reset state
        rst_n = 1'b0;
        wave  = 2'b00;
        step(3);
        chk_all_zero("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step(2);

        // Table-driven frames, two per entry
        foreach (vecs[i]) begin
            for (int f = 0; f < 2; f++) begin
                frame(vecs[i].dir, vecs[i].per, vecs[i].hi, vecs[i].duty);
            end
        end

        // Stuck high: timeout with duty 127, direction kept
        rise(DIR_CCW, 2000, 2000, 7'd127);
        push_timeout(1'b1);
        step(TIMEOUT + 16);
        chk("stuck_high_timeout", cap_if.o_timeout, 1);
        wave = 2'b00;
        step(10);
        chk("timeout_held_low", cap_if.o_timeout, 1);

        // Resume: timeout clears after the rise
        rise(DIR_CW, 128, 64, 7'd64);
        step(1);
        chk("timeout_before_rise", cap_if.o_timeout, 1);
        step(3);
        chk("timeout_cleared", cap_if.o_timeout, 0);
        step(60);
        wave = 2'b00;
        step(64);
        frame(DIR_CW, 128, 64, 7'd64);

        // Stuck low after valid frames
        rise(DIR_CCW, 128, 40, 7'd40);
        step(40);
        wave = 2'b00;
        push_timeout(1'b0);
        step(TIMEOUT);
        chk("stuck_low_timeout", cap_if.o_timeout, 1);
        chk("stuck_low_duty", cap_if.o_duty, 0);
        chk("stuck_low_dir_kept", cap_if.o_direction, DIR_CW);

        // Illegal 2'b11 for 3 cycles mid-period
        frame(DIR_CCW, 100, 30, duty_of(30, 100));
        frame(DIR_CCW, 100, 30, duty_of(30, 100));
        rise(DIR_CW, 60, 20, 7'd0);
        step(10);
        wave = 2'b11;
        for (int k = 11; k <= 16; k++) begin
            step(1);
            if (k == 13) wave = 2'b10;
            chk("err_pulse", cap_if.o_err, (k >= 12 && k <= 14) ? 1 : 0);
        end
        have_prev = 1'b0;
        step(4);
        wave = 2'b00;
        step(40);

        // Reset during a division
        frame(DIR_CW, 128, 64, 7'd64);
        frame(DIR_CW, 128, 64, 7'd64);
        rise(DIR_CW, 128, 64, 7'd64);
        void'(sb.pop_back());   // this division is aborted by the reset below
        step(6);
        rst_n = 1'b0;
        wave  = 2'b00;
        step(1);
        chk_all_zero("mid_div_reset");
        step(2);
        rst_n        = 1'b1;
        have_prev    = 1'b0;
        last_start_c = -1000;
        last_dir     = 1'b0;
        step(20);
        chk_all_zero("after_reset");

        // Period 6: every other snapshot dropped
        for (int f = 0; f < 7; f++) begin
            frame(DIR_CW, 6, 2, duty_of(2, 6));
        end
        frame(DIR_CW, 128, 64, 7'd64);
        rise(DIR_CW, 128, 64, 7'd64);
        step(64);
        wave = 2'b00;

        for (int k = 0; k < 300 && sb.size() != 0; k++) step(1);
        chk("scoreboard_drained", sb.size(), 0);
        step(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
